// File: rtl/superscalar_renamer_if.sv
// Rename/commit bundle between decode, the renamer and commit.
// RENAMER_READY_TABLE_EN adds writeback inputs and source-ready outputs.
interface superscalar_renamer_if #(
  parameter int NUM_A_REGS   = 32,
  parameter int NUM_P_REGS   = 64,
  parameter int WIDTH        = 2,
  parameter int COMMIT_WIDTH = 2
);
  localparam int AW = $clog2(NUM_A_REGS);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int CW = $clog2(NUM_P_REGS + 1);

  logic [WIDTH-1:0]           rename_valid_i;
  logic [WIDTH-1:0]           rename_we_i;
  logic [WIDTH*AW-1:0]        arch_rd_i;
  logic [WIDTH*AW-1:0]        arch_rs1_i;
  logic [WIDTH*AW-1:0]        arch_rs2_i;
  logic                       rename_ready_o;
  logic [WIDTH-1:0]           out_valid_o;
  logic [WIDTH*PW-1:0]        phys_rd_o;
  logic [WIDTH*PW-1:0]        old_phys_rd_o;
  logic [WIDTH*PW-1:0]        phys_rs1_o;
  logic [WIDTH*PW-1:0]        phys_rs2_o;
  logic [COMMIT_WIDTH-1:0]    free_valid_i;
  logic [COMMIT_WIDTH*PW-1:0] free_preg_i;
  logic [CW-1:0]              free_count_o;
`ifdef RENAMER_READY_TABLE_EN
  logic [WIDTH-1:0]           wb_valid_i;
  logic [WIDTH*PW-1:0]        wb_preg_i;
  logic [WIDTH-1:0]           rs1_ready_o;
  logic [WIDTH-1:0]           rs2_ready_o;
`endif

  modport master (
    output rename_valid_i, rename_we_i, arch_rd_i, arch_rs1_i, arch_rs2_i,
    output free_valid_i, free_preg_i,
`ifdef RENAMER_READY_TABLE_EN
    output wb_valid_i, wb_preg_i,
    input  rs1_ready_o, rs2_ready_o,
`endif
    input  rename_ready_o, out_valid_o, phys_rd_o, old_phys_rd_o,
    input  phys_rs1_o, phys_rs2_o, free_count_o
  );

  modport slave (
    input  rename_valid_i, rename_we_i, arch_rd_i, arch_rs1_i, arch_rs2_i,
    input  free_valid_i, free_preg_i,
`ifdef RENAMER_READY_TABLE_EN
    input  wb_valid_i, wb_preg_i,
    output rs1_ready_o, rs2_ready_o,
`endif
    output rename_ready_o, out_valid_o, phys_rd_o, old_phys_rd_o,
    output phys_rs1_o, phys_rs2_o, free_count_o
  );
endinterface

// File: rtl/superscalar_renamer.sv
// N-wide register renamer: RAT, circular free list, intra-group bypass, commit reclamation.
// Optional per-preg ready table enabled by defining RENAMER_READY_TABLE_EN.
module superscalar_renamer #(
  parameter int NUM_A_REGS   = 32,
  parameter int NUM_P_REGS   = 64,
  parameter int WIDTH        = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  superscalar_renamer_if.slave  bus
);
  localparam int AW       = $clog2(NUM_A_REGS);
  localparam int PW       = $clog2(NUM_P_REGS);
  localparam int CW       = $clog2(NUM_P_REGS + 1);
  localparam int NUM_FREE = NUM_P_REGS - NUM_A_REGS;

  logic [PW-1:0]       rat_q [NUM_A_REGS];
  logic [PW-1:0]       rat_d [NUM_A_REGS];
  logic [PW-1:0]       fl_q  [NUM_P_REGS];
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d, ptr, tptr;
  logic [CW-1:0]       count_q, count_d, need, cnt;
  logic [WIDTH-1:0]    alloc;
  logic                accept;
  logic [AW-1:0]       rd, rs1, rs2;
  logic [WIDTH*PW-1:0] prd_d, old_d, prs1_d, prs2_d;
  logic [WIDTH*PW-1:0] prd_q, old_q, prs1_q, prs2_q;
  logic [WIDTH-1:0]    ov_q;
  logic [COMMIT_WIDTH-1:0] push;
  logic [PW-1:0]       push_idx [COMMIT_WIDTH];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_P_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    need = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      alloc[k] = bus.rename_valid_i[k] & bus.rename_we_i[k] &
                 (bus.arch_rd_i[k*AW +: AW] != '0);
      need     = need + CW'(alloc[k]);
    end
  end

  assign accept = (count_q >= need);

  // Walking a working copy of the RAT lane by lane yields both the intra-group
  // source/old-dest bypass and last-writer-wins RAT update.
  always_comb begin
    rat_d  = rat_q;
    ptr    = head_q;
    prd_d  = '0;
    old_d  = '0;
    prs1_d = '0;
    prs2_d = '0;
    rd     = '0;
    rs1    = '0;
    rs2    = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      rd  = bus.arch_rd_i[k*AW +: AW];
      rs1 = bus.arch_rs1_i[k*AW +: AW];
      rs2 = bus.arch_rs2_i[k*AW +: AW];
      prs1_d[k*PW +: PW] = (rs1 == '0) ? '0 : rat_d[rs1];
      prs2_d[k*PW +: PW] = (rs2 == '0) ? '0 : rat_d[rs2];
      old_d[k*PW +: PW]  = rat_d[rd];
      if (alloc[k]) begin
        prd_d[k*PW +: PW] = fl_q[ptr];
        rat_d[rd]         = fl_q[ptr];
        ptr               = wrap_inc(ptr);
      end
    end
    rat_d[0] = '0;
    head_d   = ptr;
  end

  // Pushes see the post-allocation count, so the list never exceeds depth-1.
  always_comb begin
    cnt  = accept ? count_q - need : count_q;
    tptr = tail_q;
    push = '0;
    for (int unsigned c = 0; c < COMMIT_WIDTH; c++) begin
      push_idx[c] = tptr;
      if (bus.free_valid_i[c] && bus.free_preg_i[c*PW +: PW] != '0 &&
          cnt < CW'(NUM_P_REGS - 1)) begin
        push[c] = 1'b1;
        cnt     = cnt + 1'b1;
        tptr    = wrap_inc(tptr);
      end
    end
    tail_d  = tptr;
    count_d = cnt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_P_REGS; i++)
        fl_q[i] <= (i < NUM_FREE) ? PW'(i + NUM_A_REGS) : '0;
      for (int unsigned i = 0; i < NUM_A_REGS; i++)
        rat_q[i] <= PW'(i);
      head_q  <= '0;
      tail_q  <= PW'(NUM_FREE);
      count_q <= CW'(NUM_FREE);
    end else begin
      for (int unsigned c = 0; c < COMMIT_WIDTH; c++)
        if (push[c]) fl_q[push_idx[c]] <= bus.free_preg_i[c*PW +: PW];
      if (accept) begin
        rat_q  <= rat_d;
        head_q <= head_d;
      end
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ov_q   <= '0;
      prd_q  <= '0;
      old_q  <= '0;
      prs1_q <= '0;
      prs2_q <= '0;
    end else begin
      ov_q <= accept ? bus.rename_valid_i : '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (accept && bus.rename_valid_i[k]) begin
          prd_q[k*PW +: PW]  <= prd_d[k*PW +: PW];
          old_q[k*PW +: PW]  <= old_d[k*PW +: PW];
          prs1_q[k*PW +: PW] <= prs1_d[k*PW +: PW];
          prs2_q[k*PW +: PW] <= prs2_d[k*PW +: PW];
        end
      end
    end
  end

  assign bus.rename_ready_o = accept;
  assign bus.out_valid_o    = ov_q;
  assign bus.phys_rd_o      = prd_q;
  assign bus.old_phys_rd_o  = old_q;
  assign bus.phys_rs1_o     = prs1_q;
  assign bus.phys_rs2_o     = prs2_q;
  assign bus.free_count_o   = count_q;

`ifdef RENAMER_READY_TABLE_EN
  logic [NUM_P_REGS-1:0] rdy_q, rdy_d, wb_hit;
  logic [NUM_A_REGS-1:0] grp_wr;
  logic [WIDTH-1:0]      r1_d, r2_d, r1_q, r2_q;
  logic [AW-1:0]         ra1, ra2, rad;
  logic [PW-1:0]         rp1, rp2;

  // Sources written by an earlier lane of the group are never ready yet.
  always_comb begin
    wb_hit = '0;
    for (int unsigned k = 0; k < WIDTH; k++)
      if (bus.wb_valid_i[k]) wb_hit[bus.wb_preg_i[k*PW +: PW]] = 1'b1;
    grp_wr = '0;
    r1_d   = '0;
    r2_d   = '0;
    ra1    = '0;
    ra2    = '0;
    rad    = '0;
    rp1    = '0;
    rp2    = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      ra1 = bus.arch_rs1_i[k*AW +: AW];
      ra2 = bus.arch_rs2_i[k*AW +: AW];
      rad = bus.arch_rd_i[k*AW +: AW];
      rp1 = prs1_d[k*PW +: PW];
      rp2 = prs2_d[k*PW +: PW];
      r1_d[k] = (rp1 == '0) || (!grp_wr[ra1] && (rdy_q[rp1] || wb_hit[rp1]));
      r2_d[k] = (rp2 == '0) || (!grp_wr[ra2] && (rdy_q[rp2] || wb_hit[rp2]));
      if (alloc[k]) grp_wr[rad] = 1'b1;
    end
    rdy_d = rdy_q | wb_hit;
    if (accept)
      for (int unsigned k = 0; k < WIDTH; k++)
        if (alloc[k]) rdy_d[prd_d[k*PW +: PW]] = 1'b0;
    rdy_d[0] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q <= '1;
      r1_q  <= '0;
      r2_q  <= '0;
    end else begin
      rdy_q <= rdy_d;
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (accept && bus.rename_valid_i[k]) begin
          r1_q[k] <= r1_d[k];
          r2_q[k] <= r2_d[k];
        end
      end
    end
  end

  assign bus.rs1_ready_o = r1_q;
  assign bus.rs2_ready_o = r2_q;
`endif
endmodule

// File: tb/tb_superscalar_renamer.sv
// Self-checking bench for superscalar_renamer: queue-based reference model and scoreboard.
module tb_superscalar_renamer;
  localparam int NA = 32, NP = 64, W = 2, CWID = 2;
  localparam int AW = 5, PW = 6, CW = 7;

  typedef struct packed {
    logic [W-1:0]    ov;
    logic [W*PW-1:0] prd, old, rs1, rs2;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  superscalar_renamer_if #(.NUM_A_REGS(NA), .NUM_P_REGS(NP), .WIDTH(W), .COMMIT_WIDTH(CWID)) bus ();
  superscalar_renamer #(.NUM_A_REGS(NA), .NUM_P_REGS(NP), .WIDTH(W), .COMMIT_WIDTH(CWID)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb [$];
  exp_t hold;
  logic [W-1:0]  last_alloc;
  logic [PW-1:0] mrat [NA];
  logic [PW-1:0] mfl [$];
  logic [PW-1:0] rel [$];
  bit            inuse [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) mrat[a] = PW'(a);
    mfl.delete();
    for (int i = NA; i < NP; i++) mfl.push_back(PW'(i));
    hold = '0;
    hold.cnt = CW'(NP - NA);
    sb.delete();
    last_alloc = '0;
  endtask

  task automatic idle_inputs();
    bus.rename_valid_i = '0; bus.rename_we_i = '0;
    bus.arch_rd_i = '0; bus.arch_rs1_i = '0; bus.arch_rs2_i = '0;
    bus.free_valid_i = '0; bus.free_preg_i = '0;
`ifdef RENAMER_READY_TABLE_EN
    bus.wb_valid_i = '0; bus.wb_preg_i = '0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic [W-1:0] v, input logic [W-1:0] we,
                      input logic [W*AW-1:0] rd, input logic [W*AW-1:0] rs1,
                      input logic [W*AW-1:0] rs2, input logic [CWID-1:0] fv,
                      input logic [CWID*PW-1:0] fp);
    exp_t e, got;
    logic [PW-1:0] tmp [NA];
    logic [AW-1:0] a, s1, s2;
    logic [PW-1:0] p;
    int need;
    bit acc;
    bus.rename_valid_i = v; bus.rename_we_i = we;
    bus.arch_rd_i = rd; bus.arch_rs1_i = rs1; bus.arch_rs2_i = rs2;
    bus.free_valid_i = fv; bus.free_preg_i = fp;
    #1;
    need = 0;
    for (int k = 0; k < W; k++)
      if (v[k] && we[k] && rd[k*AW +: AW] != '0) need++;
    acc = (need <= mfl.size());
    chk("rename_ready", 32'(bus.rename_ready_o), 32'(acc));
    e = hold;
    e.ov = '0;
    last_alloc = '0;
    if (acc) begin
      tmp = mrat;
      for (int k = 0; k < W; k++) begin
        if (v[k]) begin
          a  = rd[k*AW +: AW];
          s1 = rs1[k*AW +: AW];
          s2 = rs2[k*AW +: AW];
          e.ov[k] = 1'b1;
          e.rs1[k*PW +: PW] = (s1 == '0) ? '0 : tmp[s1];
          e.rs2[k*PW +: PW] = (s2 == '0) ? '0 : tmp[s2];
          e.old[k*PW +: PW] = tmp[a];
          e.prd[k*PW +: PW] = '0;
          if (we[k] && a != '0) begin
            p = mfl.pop_front();
            e.prd[k*PW +: PW] = p;
            tmp[a] = p;
            last_alloc[k] = 1'b1;
          end
        end
      end
      mrat = tmp;
    end
    for (int c = 0; c < CWID; c++)
      if (fv[c] && fp[c*PW +: PW] != '0 && mfl.size() < NP - 1)
        mfl.push_back(fp[c*PW +: PW]);
    e.cnt = CW'(mfl.size());
    sb.push_back(e);
    hold = e;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("out_valid",   32'(bus.out_valid_o),   32'(got.ov));
    chk("phys_rd",     32'(bus.phys_rd_o),     32'(got.prd));
    chk("old_phys_rd", 32'(bus.old_phys_rd_o), 32'(got.old));
    chk("phys_rs1",    32'(bus.phys_rs1_o),    32'(got.rs1));
    chk("phys_rs2",    32'(bus.phys_rs2_o),    32'(got.rs2));
    chk("free_count",  32'(bus.free_count_o),  32'(got.cnt));
  endtask

  logic [W-1:0]       rv, rwe;
  logic [W*AW-1:0]    rrd, rr1, rr2;
  logic [CWID-1:0]    rfv;
  logic [CWID*PW-1:0] rfp;
  logic [PW-1:0]      q;

  initial begin
    do_reset();
    chk("reset_out_valid", 32'(bus.out_valid_o), 0);
    chk("reset_phys_rd",   32'(bus.phys_rd_o), 0);
    chk("reset_phys_rs1",  32'(bus.phys_rs1_o), 0);
    chk("reset_count",     32'(bus.free_count_o), 32);
    chk("reset_ready",     32'(bus.rename_ready_o), 1);

    // add x1,x2,x3 ; add x4,x1,x1
    step(2'b11, 2'b11, {5'd4, 5'd1}, {5'd1, 5'd2}, {5'd1, 5'd3}, '0, '0);
    chk("t1_prd0", 32'(bus.phys_rd_o[0 +: PW]), 32);
    chk("t1_old0", 32'(bus.old_phys_rd_o[0 +: PW]), 1);
    chk("t1_rs1_0", 32'(bus.phys_rs1_o[0 +: PW]), 2);
    chk("t1_rs2_0", 32'(bus.phys_rs2_o[0 +: PW]), 3);
    chk("t1_prd1", 32'(bus.phys_rd_o[PW +: PW]), 33);
    chk("t1_rs1_1", 32'(bus.phys_rs1_o[PW +: PW]), 32);
    chk("t1_rs2_1", 32'(bus.phys_rs2_o[PW +: PW]), 32);
    chk("t1_old1", 32'(bus.old_phys_rd_o[PW +: PW]), 4);
    chk("t1_count", 32'(bus.free_count_o), 30);

    // same rd in both lanes, then a reader of x5
    do_reset();
    step(2'b11, 2'b11, {5'd5, 5'd5}, '0, '0, '0, '0);
    chk("t2_prd0", 32'(bus.phys_rd_o[0 +: PW]), 32);
    chk("t2_old0", 32'(bus.old_phys_rd_o[0 +: PW]), 5);
    chk("t2_prd1", 32'(bus.phys_rd_o[PW +: PW]), 33);
    chk("t2_old1", 32'(bus.old_phys_rd_o[PW +: PW]), 32);
    step(2'b01, 2'b00, '0, {5'd0, 5'd5}, '0, '0, '0);
    chk("t2_read_x5", 32'(bus.phys_rs1_o[0 +: PW]), 33);

    // x0 as destination and sources
    step(2'b11, 2'b11, '0, '0, '0, '0, '0);
    chk("t3_prd", 32'(bus.phys_rd_o), 0);
    chk("t3_rs1", 32'(bus.phys_rs1_o), 0);
    chk("t3_rs2", 32'(bus.phys_rs2_o), 0);
    chk("t3_count", 32'(bus.free_count_o), 30);

    // drain to one entry, stall a two-allocation group while freeing p7
    while (mfl.size() > 1) begin
      if (mfl.size() >= 3) step(2'b11, 2'b11, {5'd11, 5'd10}, '0, '0, '0, '0);
      else                 step(2'b01, 2'b01, {5'd11, 5'd10}, '0, '0, '0, '0);
    end
    chk("t4_drained", 32'(bus.free_count_o), 1);
    step(2'b11, 2'b11, {5'd13, 5'd12}, '0, '0, 2'b01, {6'd0, 6'd7});
    chk("t4_stall_valid", 32'(bus.out_valid_o), 0);
    chk("t4_stall_count", 32'(bus.free_count_o), 2);
    step(2'b11, 2'b11, {5'd13, 5'd12}, '0, '0, '0, '0);
    chk("t4_accept_valid", 32'(bus.out_valid_o), 3);
    chk("t4_lane1_gets_p7", 32'(bus.phys_rd_o[PW +: PW]), 7);
    chk("t4_empty", 32'(bus.free_count_o), 0);

    // random rename/free traffic; frees recycle retired old mappings
    do_reset();
    for (int i = 0; i < NP; i++) inuse[i] = (i < NA);
    rel.delete();
    for (int n = 0; n < 200; n++) begin
      rv  = W'($urandom);
      rwe = W'($urandom);
      rrd = (W*AW)'($urandom);
      rr1 = (W*AW)'($urandom);
      rr2 = (W*AW)'($urandom);
      rfv = '0;
      rfp = '0;
      for (int c = 0; c < CWID; c++) begin
        if (rel.size() > 0 && $urandom_range(0, 9) < 7) begin
          q = rel.pop_front();
          rfv[c] = 1'b1;
          rfp[c*PW +: PW] = q;
          inuse[q] = 1'b0;
        end
      end
      step(rv, rwe, rrd, rr1, rr2, rfv, rfp);
      for (int k = 0; k < W; k++)
        if (last_alloc[k]) rel.push_back(hold.old[k*PW +: PW]);
      for (int k = 0; k < W; k++) begin
        if (bus.out_valid_o[k] && bus.phys_rd_o[k*PW +: PW] != '0) begin
          q = bus.phys_rd_o[k*PW +: PW];
          chk("no_dup_alloc", 32'(inuse[q]), 0);
          inuse[q] = 1'b1;
        end
      end
      chk("count_range", 32'(bus.free_count_o <= 63), 1);
    end

    // asynchronous reset in the middle of a cycle
    step(2'b11, 2'b11, {5'd9, 5'd8}, '0, '0, '0, '0);
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.free_count_o), 32);
    chk("async_rst_valid", 32'(bus.out_valid_o), 0);
    chk("async_rst_prd",   32'(bus.phys_rd_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step(2'b01, 2'b01, {5'd0, 5'd1}, {5'd0, 5'd8}, '0, '0, '0);
    chk("post_rst_prd", 32'(bus.phys_rd_o[0 +: PW]), 32);
    chk("post_rst_rs1", 32'(bus.phys_rs1_o[0 +: PW]), 8);

`ifdef RENAMER_READY_TABLE_EN
    do_reset();
    step(2'b01, 2'b01, {5'd0, 5'd1}, {5'd0, 5'd2}, '0, '0, '0);
    chk("rt_src_ready", 32'(bus.rs1_ready_o[0]), 1);
    step(2'b01, 2'b00, '0, {5'd0, 5'd1}, '0, '0, '0);
    chk("rt_not_ready", 32'(bus.rs1_ready_o[0]), 0);
    bus.wb_valid_i = 2'b01;
    bus.wb_preg_i  = {6'd0, 6'd32};
    step(2'b01, 2'b00, '0, {5'd0, 5'd1}, '0, '0, '0);
    chk("rt_wb_bypass", 32'(bus.rs1_ready_o[0]), 1);
    bus.wb_valid_i = '0;
    step(2'b11, 2'b01, {5'd0, 5'd3}, {5'd3, 5'd0}, '0, '0, '0);
    chk("rt_group_dep", 32'(bus.rs1_ready_o[1]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
